// File: rtl/i2c_target_if.sv
// Register-access port of the I2C target: pointer, write data/strobe out, read data in.
interface i2c_target_if;
  logic [7:0] reg_rdata;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;

  modport master (output reg_addr, reg_wdata, reg_we, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_we, output reg_rdata);
endinterface

// File: rtl/i2c_target.sv
// I2C target endpoint: oversampled SCL/SDA, 7-bit address match, pointer + burst
// write, burst read with pointer auto-increment, external register port.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h68
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      SCL,
  inout  wire       SDA,
  output logic      busy,
  i2c_target_if.master regs
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  logic [1:0] scl_ff, sda_ff;
  logic       scl_d, sda_d;
  logic       scl_q, sda_q;
  logic       rise_scl, fall_scl, start, stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], SCL};
      sda_ff <= {sda_ff[0], SDA};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign scl_q    = scl_ff[1];
  assign sda_q    = sda_ff[1];
  assign rise_scl =  scl_q & ~scl_d;
  assign fall_scl = ~scl_q &  scl_d;
  assign start    =  scl_q &  scl_d &  sda_d & ~sda_q;
  assign stop     =  scl_q &  scl_d & ~sda_d &  sda_q;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] reg_addr, addr_n, reg_wdata, wdata_n;
  logic       full, full_n, first, first_n, rw, rw_n, mack, mack_n;
  logic       inc, inc_n, sda_low, sda_low_n, reg_we, we_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd7;
      shreg     <= 8'h00;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      full      <= 1'b0;
      first     <= 1'b1;
      rw        <= 1'b0;
      mack      <= 1'b0;
      inc       <= 1'b0;
      sda_low   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_we    <= we_n;
      full      <= full_n;
      first     <= first_n;
      rw        <= rw_n;
      mack      <= mack_n;
      inc       <= inc_n;
      sda_low   <= sda_low_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    wdata_n   = reg_wdata;
    we_n      = 1'b0;
    full_n    = full;
    first_n   = first;
    rw_n      = rw;
    mack_n    = mack;
    inc_n     = 1'b0;
    sda_low_n = sda_low;
    // post-write increment lands the cycle after the strobe so addr/wdata pair stays coherent
    addr_n    = inc ? reg_addr + 8'd1 : reg_addr;
    if (stop) begin
      state_n   = IDLE;
      sda_low_n = 1'b0;
    end else if (start) begin
      state_n   = ADDR;
      bit_cnt_n = 3'd7;
      full_n    = 1'b0;
      first_n   = 1'b1;
      mack_n    = 1'b0;
      sda_low_n = 1'b0;
    end else begin
      case (state)
        ADDR, WR_BYTE: begin
          if (rise_scl) begin
            shreg_n = {shreg[6:0], sda_q};
            if (bit_cnt == 3'd0) full_n = 1'b1;
            else                 bit_cnt_n = bit_cnt - 3'd1;
          end else if (fall_scl && full) begin
            full_n    = 1'b0;
            bit_cnt_n = 3'd7;
            if (state == ADDR) begin
              if (shreg[7:1] == TARGET_ADDR) begin
                sda_low_n = 1'b1;
                rw_n      = shreg[0];
                state_n   = ADDR_ACK;
              end else begin
                sda_low_n = 1'b0;
                state_n   = IGNORE;
              end
            end else begin
              sda_low_n = 1'b1;
              state_n   = WR_ACK;
              if (first) begin
                addr_n  = shreg;
                first_n = 1'b0;
              end else begin
                wdata_n = shreg;
                we_n    = 1'b1;
                inc_n   = 1'b1;
              end
            end
          end
        end
        ADDR_ACK: if (fall_scl) begin
          if (rw) begin
            shreg_n   = regs.reg_rdata;
            sda_low_n = ~regs.reg_rdata[7];
            bit_cnt_n = 3'd7;
            state_n   = RD_BYTE;
          end else begin
            sda_low_n = 1'b0;
            first_n   = 1'b1;
            state_n   = WR_BYTE;
          end
        end
        WR_ACK: if (fall_scl) begin
          sda_low_n = 1'b0;
          state_n   = WR_BYTE;
        end
        // bit_cnt counts bits still to present after the MSB already on the bus
        RD_BYTE: if (fall_scl) begin
          if (bit_cnt == 3'd0) begin
            sda_low_n = 1'b0;
            state_n   = RD_ACK;
          end else begin
            shreg_n   = {shreg[6:0], 1'b0};
            sda_low_n = ~shreg[6];
            bit_cnt_n = bit_cnt - 3'd1;
          end
        end
        RD_ACK: begin
          if (rise_scl) begin
            if (!sda_q) begin
              addr_n = reg_addr + 8'd1;
              mack_n = 1'b1;
            end else begin
              state_n = IGNORE;
            end
          end else if (fall_scl && mack) begin
            mack_n    = 1'b0;
            shreg_n   = regs.reg_rdata;
            sda_low_n = ~regs.reg_rdata[7];
            bit_cnt_n = 3'd7;
            state_n   = RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  assign SDA            = sda_low ? 1'b0 : 1'bz;
  assign busy           = (state != IDLE);
  assign regs.reg_addr  = reg_addr;
  assign regs.reg_wdata = reg_wdata;
  assign regs.reg_we    = reg_we;

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C master driving i2c_target against a transaction-level model.
module tb_i2c_target;
  localparam logic [6:0] TADDR = 7'h68;
  localparam int TL = 8;
  localparam int TH = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m_low = 1'b0;
  logic busy;
  wire  sda_bus;

  always #5 clk = ~clk;

  assign sda_bus = sda_m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_target_if regs();
  logic [7:0] umem [256];
  assign regs.reg_rdata = umem[regs.reg_addr];

  i2c_target #(.TARGET_ADDR(TADDR)) dut (
    .clk(clk), .rst_n(rst_n), .SCL(scl_m), .SDA(sda_bus), .busy(busy), .regs(regs)
  );

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  logic       we_prev = 1'b0;
  logic [15:0] exp16;
  logic [7:0] mmem [256];
  logic [7:0] exp_ptr = 8'h00;
  logic [15:0] wq[$];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Write scoreboard: each strobe must match the next predicted (addr,data) and be one cycle wide
  always @(negedge clk) begin
    if (!rst_n) begin
      we_prev = 1'b0;
    end else begin
      if (regs.reg_we) begin
        we_cnt++;
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL we_unexpected: got addr=%02h data=%02h, required no strobe", regs.reg_addr, regs.reg_wdata);
        end else begin
          exp16 = wq.pop_front();
          if ({regs.reg_addr, regs.reg_wdata} !== exp16) begin
            failures++;
            $display("FAIL we_pair: got %02h/%02h required %02h/%02h", regs.reg_addr, regs.reg_wdata, exp16[15:8], exp16[7:0]);
          end
        end
        checks++;
        if (we_prev) begin
          failures++;
          $display("FAIL we_width: got strobe wider than 1 clk, required 1");
        end
        umem[regs.reg_addr] = regs.reg_wdata;
      end
      we_prev = regs.reg_we;
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m_low = 1'b0;
    wclk(TL - 2);
    scl_m = 1'b1;
    wclk(TH);
    sda_m_low = 1'b1;
    wclk(TH);
    scl_m = 1'b0;
    wclk(2);
  endtask

  task automatic i2c_stop;
    sda_m_low = 1'b1;
    wclk(TL - 2);
    scl_m = 1'b1;
    wclk(TH);
    sda_m_low = 1'b0;
    wclk(TH);
  endtask

  task automatic bitx(input logic b, output logic r);
    sda_m_low = ~b;
    wclk(TL - 2);
    scl_m = 1'b1;
    wclk(TH / 2);
    r = sda_bus;
    wclk(TH - TH / 2);
    scl_m = 1'b0;
    wclk(2);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bitx(d[i], r);
    bitx(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) bitx(1'b1, d[i]);
    bitx(~mack, r);
  endtask

  task automatic wr_txn(input logic [6:0] a, input logic [7:0] ptr);
    logic ack;
    logic match;
    match = (a == TADDR);
    i2c_start;
    wr_byte({a, 1'b0}, ack);
    chk("wr_addr_ack", ack, !match);
    chk("busy_active", busy, 1);
    wr_byte(ptr, ack);
    chk("wr_ptr_ack", ack, !match);
    if (match) exp_ptr = ptr;
    foreach (txq[i]) begin
      if (match) begin
        wq.push_back({exp_ptr, txq[i]});
        mmem[exp_ptr] = txq[i];
      end
      wr_byte(txq[i], ack);
      chk("wr_data_ack", ack, !match);
      if (match) exp_ptr++;
    end
    i2c_stop;
    chk("busy_after_p", busy, 0);
    chk("ptr_after_wr", regs.reg_addr, exp_ptr);
  endtask

  task automatic rd_txn(input logic [7:0] ptr, input int n);
    logic ack;
    logic [7:0] d;
    rxq.delete();
    i2c_start;
    wr_byte({TADDR, 1'b0}, ack);
    chk("rd_addrw_ack", ack, 0);
    chk("busy_active", busy, 1);
    wr_byte(ptr, ack);
    chk("rd_ptr_ack", ack, 0);
    exp_ptr = ptr;
    i2c_start;
    wr_byte({TADDR, 1'b1}, ack);
    chk("rd_addrr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      rd_byte(i < n - 1, d);
      chk("rd_data", d, mmem[exp_ptr]);
      rxq.push_back(d);
      if (i < n - 1) exp_ptr++;
    end
    i2c_stop;
    chk("busy_after_p", busy, 0);
    chk("ptr_after_rd", regs.reg_addr, exp_ptr);
  endtask

  initial begin
    logic ack, r;
    logic [7:0] v, ptr;
    logic [6:0] a;
    int n, kind, wc0;
    logic [7:0] pat;

    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      umem[i] = v;
      mmem[i] = v;
    end
    wclk(4);
    chk("rst_busy", busy, 0);
    chk("rst_addr", regs.reg_addr, 8'h00);
    chk("rst_wdata", regs.reg_wdata, 8'h00);
    chk("rst_we", regs.reg_we, 0);
    chk("rst_sda", sda_bus, 1);
    rst_n = 1'b1;
    wclk(4);

    // pointer write then repeated-START read of one byte, NACKed
    umem[8'h75] = 8'h68;
    mmem[8'h75] = 8'h68;
    wc0 = we_cnt;
    rd_txn(8'h75, 1);
    chk("rs_read_lit", rxq[0], 8'h68);
    chk("rs_no_we", we_cnt - wc0, 0);
    chk("rs_ptr_lit", regs.reg_addr, 8'h75);

    // burst write
    wc0 = we_cnt;
    txq = '{8'hAA, 8'h55};
    wr_txn(TADDR, 8'h10);
    chk("bw_we_cnt", we_cnt - wc0, 2);
    chk("bw_ptr_lit", regs.reg_addr, 8'h12);
    chk("bw_wdata_lit", regs.reg_wdata, 8'h55);
    chk("bw_mem10", umem[8'h10], 8'hAA);
    chk("bw_mem11", umem[8'h11], 8'h55);

    // address mismatch
    wc0 = we_cnt;
    txq.delete();
    wr_txn(7'h50, 8'h33);
    chk("mm_no_we", we_cnt - wc0, 0);
    chk("mm_ptr_lit", regs.reg_addr, 8'h12);

    // burst read across the 0xFF -> 0x00 wrap
    umem[8'hFE] = 8'h11; mmem[8'hFE] = 8'h11;
    umem[8'hFF] = 8'h22; mmem[8'hFF] = 8'h22;
    umem[8'h00] = 8'h33; mmem[8'h00] = 8'h33;
    rd_txn(8'hFE, 3);
    chk("wrap_b0", rxq[0], 8'h11);
    chk("wrap_b1", rxq[1], 8'h22);
    chk("wrap_b2", rxq[2], 8'h33);
    chk("wrap_ptr_lit", regs.reg_addr, 8'h00);

    // START inside a data byte discards the partial byte
    wc0 = we_cnt;
    i2c_start;
    wr_byte({TADDR, 1'b0}, ack);
    chk("mb_addr_ack", ack, 0);
    wr_byte(8'h20, ack);
    chk("mb_ptr_ack", ack, 0);
    exp_ptr = 8'h20;
    pat = 8'hA5;
    for (int i = 7; i >= 4; i--) bitx(pat[i], r);
    i2c_start;
    wr_byte({TADDR, 1'b0}, ack);
    chk("mb2_addr_ack", ack, 0);
    wr_byte(8'h40, ack);
    chk("mb2_ptr_ack", ack, 0);
    exp_ptr = 8'h40;
    wq.push_back({8'h40, 8'h01});
    mmem[8'h40] = 8'h01;
    wr_byte(8'h01, ack);
    chk("mb2_data_ack", ack, 0);
    exp_ptr = 8'h41;
    i2c_stop;
    chk("mb_we_cnt", we_cnt - wc0, 1);
    chk("mb_ptr_lit", regs.reg_addr, 8'h41);
    chk("mb_busy", busy, 0);

    // reset while the target holds SDA low for the address ACK
    i2c_start;
    pat = {TADDR, 1'b0};
    for (int i = 7; i >= 0; i--) bitx(pat[i], r);
    sda_m_low = 1'b0;
    wclk(TL - 2);
    scl_m = 1'b1;
    wclk(2);
    chk("ra_ack_driven", sda_bus, 0);
    rst_n = 1'b0;
    #1;
    chk("ra_sda_z", sda_bus, 1);
    chk("ra_busy", busy, 0);
    chk("ra_addr", regs.reg_addr, 8'h00);
    chk("ra_wdata", regs.reg_wdata, 8'h00);
    chk("ra_we", regs.reg_we, 0);
    wclk(3);
    rst_n = 1'b1;
    exp_ptr = 8'h00;
    wclk(TH);
    scl_m = 1'b0;
    wclk(2);
    i2c_stop;
    txq = '{8'h5A};
    wr_txn(TADDR, 8'h30);
    rd_txn(8'h30, 1);
    chk("ra_after_lit", rxq[0], 8'h5A);

    // randomized traffic
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 2);
      ptr = 8'($urandom);
      n = $urandom_range(0, 4);
      txq.delete();
      for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
      case (kind)
        0: wr_txn(TADDR, ptr);
        1: rd_txn(ptr, n + 1);
        default: begin
          a = 7'($urandom);
          if (a == TADDR) a = a ^ 7'h01;
          wr_txn(a, ptr);
        end
      endcase
    end

    wclk(4);
    chk("we_pending", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
